// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer
//   Two-entry skid buffer between fetch and decode. Every output, in_ready
//   included, comes from registered state only, so decode back-pressure never
//   reaches fetch combinationally. A synchronous flush drops all buffered
//   entries and any entry offered in the same cycle.
//
// Build option: define FETCH_DECODE_BUFFER_NOP_FILL_EN to drive NOP_INSTR and
//   a zero PC on the output whenever out_valid is 0. Without it, the output
//   shows the stale main-register contents.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   flush      discard all buffered entries (highest priority)
//   in_valid   fetch presents (in_pc, in_instr)
//   in_ready   buffer can accept an entry this cycle
//   out_valid  head entry valid for decode
//   out_ready  decode accepts the head entry this cycle
//   out_pc     PC of head entry
//   out_instr  instruction of head entry
//
// state   | meaning
// --------+--------------------------------------
// S_EMPTY | no entries held
// S_ONE   | main register holds the head entry
// S_FULL  | main holds head, skid holds the next
module fetch_decode_buffer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] main_instr_q, main_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            in_fire;
  logic            out_fire;

  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Data registers only load on the events below; consuming or flushing an
  // entry changes state alone, leaving the old contents visible.
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
            state_d      = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end else if (in_fire) begin
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
            state_d      = S_FULL;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            state_d      = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

`ifdef FETCH_DECODE_BUFFER_NOP_FILL_EN
  assign out_pc    = out_valid ? main_pc_q    : '0;
  assign out_instr = out_valid ? main_instr_q : NOP_INSTR;
`else
  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;
`endif

endmodule
